// File: rtl/ft64v8d_pkg.sv
// Shared FT64v8d opcode constants, size-prefix codes and the length/prefix
// decode helpers used by the instruction aligner.
package ft64v8d_pkg;

  localparam logic [7:0] I_BRK   = 8'h00;
  localparam logic [7:0] I_CLI   = 8'h58;
  localparam logic [7:0] I_NOP   = 8'hEA;
  localparam logic [7:0] I_RTI   = 8'h40;
  localparam logic [7:0] I_RTS   = 8'h60;
  localparam logic [7:0] I_WAI   = 8'hCB;
  localparam logic [7:0] I_JMP   = 8'h4C;
  localparam logic [7:0] I_JSR   = 8'h20;
  localparam logic [7:0] I_JMF   = 8'h5C;
  localparam logic [7:0] I_JSF   = 8'h22;

  // Each ALU op has register, 6-bit, 14-bit and 30-bit immediate forms.
  localparam logic [7:0] I_ADD   = 8'h10;
  localparam logic [7:0] I_ADD6  = 8'h11;
  localparam logic [7:0] I_ADD14 = 8'h12;
  localparam logic [7:0] I_ADD30 = 8'h13;
  localparam logic [7:0] I_AND   = 8'h14;
  localparam logic [7:0] I_AND6  = 8'h15;
  localparam logic [7:0] I_AND14 = 8'h16;
  localparam logic [7:0] I_AND30 = 8'h17;
  localparam logic [7:0] I_CMP   = 8'h18;
  localparam logic [7:0] I_CMP6  = 8'h19;
  localparam logic [7:0] I_CMP14 = 8'h1A;
  localparam logic [7:0] I_CMP30 = 8'h1B;
  localparam logic [7:0] I_EOR   = 8'h1C;
  localparam logic [7:0] I_EOR6  = 8'h1D;
  localparam logic [7:0] I_EOR14 = 8'h1E;
  localparam logic [7:0] I_EOR30 = 8'h1F;
  localparam logic [7:0] I_OR    = 8'h30;
  localparam logic [7:0] I_OR6   = 8'h31;
  localparam logic [7:0] I_OR14  = 8'h32;
  localparam logic [7:0] I_OR30  = 8'h33;

  localparam logic [7:0] I_BYTE  = 8'hF0;
  localparam logic [7:0] I_UBYTE = 8'hF1;
  localparam logic [7:0] I_HALF  = 8'hF2;
  localparam logic [7:0] I_UHALF = 8'hF3;
  localparam logic [7:0] I_WORD  = 8'hF4;
  localparam logic [7:0] I_UWORD = 8'hF5;

  typedef enum logic [2:0] {
    PFX_NONE  = 3'd0,
    PFX_BYTE  = 3'd1,
    PFX_UBYTE = 3'd2,
    PFX_HALF  = 3'd3,
    PFX_UHALF = 3'd4,
    PFX_WORD  = 3'd5,
    PFX_UWORD = 3'd6
  } pfx_e;

  function automatic logic is_prefix(input logic [7:0] opc);
    return opc inside {I_BYTE, I_UBYTE, I_HALF, I_UHALF, I_WORD, I_UWORD};
  endfunction

  function automatic pfx_e prefix_code(input logic [7:0] opc);
    case (opc)
      I_BYTE:  return PFX_BYTE;
      I_UBYTE: return PFX_UBYTE;
      I_HALF:  return PFX_HALF;
      I_UHALF: return PFX_UHALF;
      I_WORD:  return PFX_WORD;
      I_UWORD: return PFX_UWORD;
      default: return PFX_NONE;
    endcase
  endfunction

  // Undefined opcodes decode as single-byte so the stream always advances.
  function automatic logic [2:0] insn_len(input logic [7:0] opc);
    case (opc)
      I_ADD, I_ADD6, I_AND, I_AND6, I_CMP, I_CMP6,
      I_EOR, I_EOR6, I_OR, I_OR6:                       return 3'd3;
      I_ADD14, I_AND14, I_CMP14, I_EOR14, I_OR14:       return 3'd4;
      I_ADD30, I_AND30, I_CMP30, I_EOR30, I_OR30:       return 3'd6;
      I_JMP, I_JSR:                                     return 3'd4;
      I_JMF, I_JSF:                                     return 3'd6;
      I_BRK:                                            return 3'd2;
      I_CLI, I_NOP, I_RTI, I_RTS, I_WAI:                return 3'd1;
      default:                                          return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ft64v8d_insn_aligner_if.sv
// Fetch-side and decode-side handshakes of the FT64v8d instruction aligner.
interface ft64v8d_insn_aligner_if #(
  parameter int FETCH_BYTES = 8,
  parameter int MAX_LEN     = 6,
  parameter int AW          = 32
);
  // Both channels: a transfer happens on a rising clock edge where valid and
  // ready are both high; valid and payload hold until that edge, and neither
  // valid nor ready depends combinationally on the other side's signals.
  logic                     f_valid;
  logic                     f_ready;
  logic [8*FETCH_BYTES-1:0] f_data;
  logic                     o_valid;
  logic                     o_ready;
  logic [8*MAX_LEN-1:0]     o_insn;
  logic [2:0]               o_len;
  logic [2:0]               o_prefix;
  logic [AW-1:0]            o_pc;

  modport master (
    input  f_valid, f_data, o_ready,
    output f_ready, o_valid, o_insn, o_len, o_prefix, o_pc
  );

  modport slave (
    output f_valid, f_data, o_ready,
    input  f_ready, o_valid, o_insn, o_len, o_prefix, o_pc
  );
endinterface

// File: rtl/ft64v8d_byteq.sv
// Circular byte queue: fixed-width push, variable pop, and a rotated view of
// the bytes starting at the head so the consumer always sees them aligned.
module ft64v8d_byteq #(
  parameter int QUEUE_BYTES = 16,
  parameter int PUSH_BYTES  = 8,
  parameter int VIEW_BYTES  = 7,
  localparam int IW = $clog2(QUEUE_BYTES),
  localparam int CW = $clog2(QUEUE_BYTES + 1),
  localparam int PW = $clog2(VIEW_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic [8*PUSH_BYTES-1:0] i_push_data,
  input  logic [PW-1:0]           i_pop_cnt,
  output logic                    o_space_ok,
  output logic [CW-1:0]           o_count,
  output logic [8*VIEW_BYTES-1:0] o_view
);

  logic [7:0]    r_mem [QUEUE_BYTES];
  logic [IW-1:0] r_head;
  logic [IW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;

  // Offsets never exceed QUEUE_BYTES, so one conditional subtract is enough.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= QUEUE_BYTES) s = s - QUEUE_BYTES;
    return IW'(s);
  endfunction

  // Space is judged on the registered count only; same-cycle pops are not credited.
  assign o_space_ok = (CW'(QUEUE_BYTES) - r_count) >= CW'(PUSH_BYTES);
  assign w_push     = i_push && o_space_ok;
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= wrap_add(r_tail, PUSH_BYTES);
      r_head  <= wrap_add(r_head, int'(i_pop_cnt));
      r_count <= r_count + (w_push ? CW'(PUSH_BYTES) : '0) - CW'(i_pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_clear && w_push) begin
      for (int k = 0; k < PUSH_BYTES; k++) begin
        r_mem[wrap_add(r_tail, k)] <= i_push_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    o_view = '0;
    for (int k = 0; k < VIEW_BYTES; k++) begin
      o_view[8*k +: 8] = r_mem[wrap_add(r_head, k)];
    end
  end

endmodule

// File: rtl/ft64v8d_insn_aligner.sv
// FT64v8d instruction aligner: decodes the instruction at the byte-queue head,
// folds one size prefix into it and hands it to the decoder with PC and length.
module ft64v8d_insn_aligner
  import ft64v8d_pkg::*;
#(
  parameter int FETCH_BYTES = 8,
  parameter int QUEUE_BYTES = 16,
  parameter int MAX_LEN     = 6,
  parameter int AW          = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [AW-1:0]                      flush_pc,
  ft64v8d_insn_aligner_if.master             bus,
  output logic [$clog2(QUEUE_BYTES+1)-1:0]   o_dbg_count
);

  localparam int CW = $clog2(QUEUE_BYTES + 1);
  localparam int VB = MAX_LEN + 1;
  localparam int PW = $clog2(VB + 1);

  logic [CW-1:0]        w_count;
  logic [8*VB-1:0]      w_view;
  logic                 w_space_ok;
  logic [PW-1:0]        w_pop_cnt;
  logic [AW-1:0]        r_pc;
  logic [7:0]           w_b0;
  logic [7:0]           w_b1;
  logic [7:0]           w_opc;
  logic                 w_pfx;
  logic                 w_drop;
  logic                 w_valid;
  logic                 w_take;
  logic [2:0]           w_len;
  logic [CW-1:0]        w_need;
  logic [8*MAX_LEN-1:0] w_body;
  logic [8*MAX_LEN-1:0] w_insn;

  ft64v8d_byteq #(
    .QUEUE_BYTES (QUEUE_BYTES),
    .PUSH_BYTES  (FETCH_BYTES),
    .VIEW_BYTES  (VB)
  ) u_byteq (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (flush),
    .i_push      (bus.f_valid),
    .i_push_data (bus.f_data),
    .i_pop_cnt   (w_pop_cnt),
    .o_space_ok  (w_space_ok),
    .o_count     (w_count),
    .o_view      (w_view)
  );

  assign w_b0   = w_view[7:0];
  assign w_b1   = w_view[15:8];
  assign w_pfx  = is_prefix(w_b0);
  assign w_opc  = w_pfx ? w_b1 : w_b0;
  assign w_len  = insn_len(w_opc);
  assign w_need = CW'(w_len) + CW'(w_pfx);

  // A prefix followed by a prefix is discarded on its own, one per cycle.
  assign w_drop  = w_pfx && is_prefix(w_b1) && (w_count >= CW'(2));
  assign w_valid = !w_drop && (w_count >= w_need);
  assign w_take  = w_valid && bus.o_ready;

  assign w_pop_cnt = w_take ? PW'(w_need) : (w_drop ? PW'(1) : '0);

  assign w_body = w_pfx ? w_view[8*VB-1:8] : w_view[8*MAX_LEN-1:0];

  always_comb begin
    w_insn = '0;
    if (w_valid) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (k < int'(w_len)) w_insn[8*k +: 8] = w_body[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        r_pc <= '0;
    else if (flush) r_pc <= flush_pc;
    else            r_pc <= r_pc + AW'(w_pop_cnt);
  end

  assign bus.f_ready  = w_space_ok;
  assign bus.o_valid  = w_valid;
  assign bus.o_insn   = w_insn;
  assign bus.o_len    = w_valid ? w_len : 3'd1;
  assign bus.o_prefix = (w_valid && w_pfx) ? 3'(prefix_code(w_b0)) : 3'(PFX_NONE);
  assign bus.o_pc     = r_pc;
  assign o_dbg_count  = w_count;

endmodule

// File: doc/ft64v8d_insn_aligner.md
Name: ft64v8d_insn_aligner

Overview:
- Byte-granular instruction aligner that sits between the FT64v8d fetch unit and the decoder.
- Accepts fixed-width fetch chunks into a byte queue and decodes the length of the instruction at the head.
- Folds at most one size prefix into the following instruction.
- Presents one left-aligned instruction per cycle over a valid/ready handshake, with its PC and length.

Parameters:
- FETCH_BYTES, 8, bytes per fetch chunk.
- QUEUE_BYTES, 16, byte-queue capacity; must be >= FETCH_BYTES + MAX_LEN + 1.
- MAX_LEN, 6, longest non-prefix instruction in bytes.
- AW, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard queue contents and restart at flush_pc.
- flush_pc  in  AW  new head PC on flush.
- f_valid  in  1  fetch chunk valid.
- f_ready  out  1  aligner can accept a full chunk.
- f_data  in  8*FETCH_BYTES  chunk; byte 0 in [7:0] is the lowest address.
- o_valid  out  1  complete instruction at head.
- o_ready  in  1  decoder consumes instruction.
- o_insn  out  8*MAX_LEN  instruction bytes, opcode in [7:0]; unused upper bytes are zero.
- o_len  out  3  instruction length 1..MAX_LEN, excluding the prefix.
- o_prefix  out  3  0 = none; 1..6 = BYTE, UBYTE, HALF, UHALF, WORD, UWORD.
- o_pc  out  AW  PC of the first byte consumed, which is the prefix byte if present.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Queue count = 0, head PC = 0.
  - o_valid = 0, o_insn = 0, o_len = 1, o_prefix = 0, o_pc = 0, f_ready = 1.
- Reset mid-stream discards all bytes and any partially assembled instruction.
- Queue storage: circular byte array, with head index, tail index and count. Count width is $clog2(QUEUE_BYTES+1).
- Index arithmetic is modulo QUEUE_BYTES; wrap-around must be seamless for instructions straddling the array end.
- f_ready = (QUEUE_BYTES - count) >= FETCH_BYTES.
  - Evaluate on registered count only; do not credit bytes consumed in the same cycle.
  - Accept when f_valid && f_ready. Bytes become visible at the head on the next cycle.
- Length decode uses the package function insn_len(opcode):
  - Prefix opcodes: 1.
  - ADD/AND/CMP/EOR/OR register and 6-bit forms: 3.
  - 14-bit immediate forms: 4.
  - 30-bit immediate forms: 6.
  - JMP, JSR: 4.
  - JMF, JSF: 6.
  - BRK: 2.
  - CLI, NOP, RTI, RTS, WAI, undefined: 1.
- Prefix folding:
  - If the head byte is a prefix, P = 1 and the opcode is the byte at head+1; otherwise P = 0.
  - A prefix followed by another prefix: the first prefix is consumed and dropped alone, without asserting o_valid. This takes one cycle, and the second prefix becomes the head.
- Output is combinational from registered queue state:
  - o_valid = count >= P + 1 && count >= P + insn_len(opcode).
  - If count == 1 and the head byte is a prefix, o_valid = 0.
- Consume:
  - On o_valid && o_ready, the head advances by P + o_len and the head PC advances by P + o_len (modulo 2^AW).
  - Throughput is one instruction per cycle.
- o_valid may not deassert without a consume or flush. o_insn must remain stable while o_valid && !o_ready.
- Simultaneous accept and consume in one cycle: count_next = count + FETCH_BYTES - consumed.
- Flush has priority over accept, consume and prefix drop:
  - Next cycle: count = 0 and head PC = flush_pc.
  - A chunk offered in the flush cycle is discarded.
  - f_ready during the flush cycle follows the normal rule; the accept is simply ignored.
- Empty queue: o_valid = 0.
- Full queue: f_ready = 0. The queue never overflows.

Decomposition:
- Shared package ft64v8d_pkg holds:
  - Opcode constants (I_ADD … I_UWORD).
  - The prefix-code enum.
  - The function insn_len(opcode) returning 3 bits.
  - The function is_prefix(opcode).
- One sub-module, ft64v8d_byteq: circular byte queue with parametrised push width and a variable pop count (0..MAX_LEN+1). It exposes the head MAX_LEN+1 bytes in a rotated, aligned view.
- The aligner top holds:
  - length/prefix decode,
  - the handshake,
  - the PC register,
  - flush control.

Test Plan:
- Reset, then flush_pc = 0x1000; push chunk {I_ADD,r,r,I_NOP,I_ADD30,i,i,i} with o_ready = 1:
  - cycle+1: o_len = 3, o_pc = 0x1000;
  - cycle+2: o_len = 1, o_pc = 0x1003;
  - the ADD30 is held with o_valid = 0 until the next chunk supplies its final byte;
  - after that push: o_len = 6, o_pc = 0x1004.
- Prefix fold: bytes {I_UHALF, I_ADD14, a, b, c} give one output: o_prefix = 4, o_len = 4, o_pc = prefix address; the head advances by 5.
- Double prefix {I_BYTE, I_WORD, I_CMP, x, y}: no output in the drop cycle, then o_prefix = 5, o_len = 3, with o_pc at the I_WORD address.
- Backpressure: o_ready = 0 with the queue filled to 16:
  - f_ready = 0 and the queue holds;
  - o_insn is stable for 10 cycles;
  - releasing o_ready drains in order with no byte loss across the index-15→0 wrap.
- Flush, f_valid and o_valid all asserted in the same cycle with flush_pc = 0x2000:
  - next cycle o_valid = 0 and count = 0;
  - the next chunk's first instruction reports o_pc = 0x2000.
- Synchronous reset asserted mid-instruction (3 of 6 bytes queued): next cycle o_valid = 0, f_ready = 1, o_pc = 0.
